// File: rtl/user_au_pkg.sv
// Shared types and constants for the user_au audio path.
package user_au_pkg;

  localparam int SampleWidth = 32;
  localparam int ChanWidth   = 16;
  localparam int FrameBits   = 32;
  localparam int SlotWidth   = $clog2(FrameBits);

  typedef struct packed {
    logic [ChanWidth-1:0] left;
    logic [ChanWidth-1:0] right;
  } stereo_sample_t;

  // Word select for a given bit slot: high while the right channel is coming,
  // which starts one slot before the right MSB and ends one slot before the left MSB.
  function automatic logic ws_for_slot(input logic [SlotWidth-1:0] slot);
    return (slot >= SlotWidth'(15)) && (slot <= SlotWidth'(30));
  endfunction

endpackage

// File: rtl/user_au_i2s_clkgen.sv
// I2S bit-clock generator: divides clk_i down to sck and flags falling edges.
module user_au_i2s_clkgen #(
  parameter int ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic fall_o
);

  localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  logic [DivW-1:0] div_cnt;
  logic            sck_q;
  logic            wrap;

  assign wrap   = en_i && (div_cnt == DivLast);
  // fall_o marks the cycle whose closing clk edge drives sck low, so that
  // consumers can update their own flops on that very same edge.
  assign fall_o = wrap && sck_q;
  assign sck_o  = sck_q;

  // Half-period counter and sck toggle flop; both held at zero while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (!en_i) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) sck_q <= ~sck_q;
    end
  end

endmodule

// File: rtl/user_au_i2s_tx.sv
// Philips I2S transmitter: one-entry holding register in front of a 32-bit
// frame shifter; sck/ws/sd all come straight from flops.
module user_au_i2s_tx
  import user_au_pkg::*;
#(
  parameter int ClkDiv = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [SampleWidth-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   i2s_sck_o,
  output logic                   i2s_ws_o,
  output logic                   i2s_sd_o,
  output logic                   underrun_o
);

  stereo_sample_t         hold_q;
  logic                   hold_full;
  logic [FrameBits-1:0]   sh_q;
  logic [SlotWidth-1:0]   bit_cnt;
  logic                   ws_q;
  logic                   sd_q;
  logic                   underrun_q;

  logic                   fall;
  logic                   accept;
  logic                   load;
  logic [SlotWidth-1:0]   bit_next;
  logic [FrameBits-1:0]   frame_next;

  user_au_i2s_clkgen #(
    .ClkDiv (ClkDiv)
  ) u_clkgen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .sck_o  (i2s_sck_o),
    .fall_o (fall)
  );

  assign ready_o    = ~hold_full;
  assign accept     = valid_i & ~hold_full;
  assign load       = fall && (bit_cnt == SlotWidth'(FrameBits - 1));
  assign bit_next   = bit_cnt + 1'b1;
  // On a frame boundary the new frame is the held sample, or silence if none.
  assign frame_next = load ? (hold_full ? FrameBits'(hold_q) : '0) : sh_q;

  // Holding register: accepts regardless of en_i, emptied by a frame load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= stereo_sample_t'(data_i);
      hold_full <= 1'b1;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  // Frame shifter, slot counter and serial outputs, all advancing on sck falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q       <= '0;
      bit_cnt    <= SlotWidth'(FrameBits - 1);
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!en_i) begin
      // Abandon any frame in progress; the next enable starts from a boundary.
      sh_q       <= '0;
      bit_cnt    <= SlotWidth'(FrameBits - 1);
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else if (fall) begin
      sh_q    <= frame_next;
      bit_cnt <= bit_next;
      ws_q    <= ws_for_slot(bit_next);
      sd_q    <= frame_next[SlotWidth'(FrameBits - 1) - bit_next];
      if (load && !hold_full) underrun_q <= 1'b1;
    end
  end

  assign i2s_ws_o   = ws_q;
  assign i2s_sd_o   = sd_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_user_au_i2s_tx.sv
// Bench for user_au_i2s_tx: two instances (ClkDiv 2 and 1) checked every
// cycle against an arithmetic model of the I2S frame timing.
module tb_user_au_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [1:0]  valid;
  logic [31:0] data [2];
  logic [1:0]  ready, sck, ws, sd, und;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state per instance.
  int          div_of [2];
  int          t      [2];   // edges elapsed since enable
  logic [31:0] m_hold [2];
  logic [31:0] m_frame[2];
  bit          m_full [2];
  bit          m_und  [2];
  bit          m_acc  [2];
  int          pend   [2];   // samples the source still wants to send
  bit          inc_mode[2];
  bit          gappy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  user_au_i2s_tx #(.ClkDiv(2)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .i2s_sck_o(sck[0]), .i2s_ws_o(ws[0]), .i2s_sd_o(sd[0]),
    .underrun_o(und[0])
  );

  user_au_i2s_tx #(.ClkDiv(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .i2s_sck_o(sck[1]), .i2s_ws_o(ws[1]), .i2s_sd_o(sd[1]),
    .underrun_o(und[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model one clock edge from the specification's timing rules.
  task automatic model_edge(input int i);
    bit load;
    int d;
    d = div_of[i];
    m_acc[i] = 1'b0;
    if (!rst_n) begin
      t[i] = 0; m_full[i] = 0; m_und[i] = 0; m_frame[i] = 0; m_hold[i] = 0;
      return;
    end
    t[i] = en[i] ? t[i] + 1 : 0;
    load = en[i] && (t[i] >= 2*d) && (((t[i] - 2*d) % (64*d)) == 0);
    m_acc[i] = valid[i] && !m_full[i];
    if (load) begin
      m_frame[i] = m_full[i] ? m_hold[i] : 32'h0;
      if (!m_full[i]) m_und[i] = 1'b1;
      m_full[i] = 1'b0;
    end
    if (m_acc[i]) begin
      m_hold[i] = data[i];
      m_full[i] = 1'b1;
    end
    if (!en[i]) begin
      m_und[i] = 1'b0;
      m_frame[i] = 32'h0;
    end
  endtask

  task automatic check_outputs(input int i);
    int d, s;
    logic e_sck, e_ws, e_sd;
    d = div_of[i];
    e_sck = ((t[i] / d) % 2) == 1;
    e_ws = 1'b0;
    e_sd = 1'b0;
    if (t[i] >= 2*d) begin
      s = (t[i] / (2*d) - 1) % 32;
      e_ws = (s >= 15) && (s <= 30);
      e_sd = m_frame[i][31-s];
    end
    chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(!m_full[i]));
    chk($sformatf("sck%0d", i), 32'(sck[i]), 32'(e_sck));
    chk($sformatf("ws%0d", i), 32'(ws[i]), 32'(e_ws));
    chk($sformatf("sd%0d", i), 32'(sd[i]), 32'(e_sd));
    chk($sformatf("underrun%0d", i), 32'(und[i]), 32'(m_und[i]));
  endtask

  // Advance one cycle: model the edge, check after it, then drive new inputs.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      if (m_acc[i]) begin
        pend[i]--;
        data[i] = inc_mode[i] ? data[i] + 32'd1 : $urandom;
      end
      valid[i] = (pend[i] > 0) && (!gappy || ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    div_of[0] = 2; div_of[1] = 1;
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; m_full[i] = 0; m_und[i] = 0; m_frame[i] = 0; m_hold[i] = 0;
      pend[i] = 0; inc_mode[i] = 0; data[i] = 32'h0;
    end
    gappy = 0;
    en = 2'b00; valid = 2'b00;

    // Reset, then 1000 idle cycles with the transmitter disabled.
    rst_n = 1'b0;
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    run(1000);

    // Single frame at ClkDiv 2 with a known pattern.
    data[0] = 32'hA5F0_0F5A; pend[0] = 1; valid[0] = 1'b1;
    run(2);
    en[0] = 1'b1;
    run(200);
    en[0] = 1'b0;
    run(4);

    // Back-to-back incrementing samples; also exercises accept right after a load.
    inc_mode[0] = 1; data[0] = 32'h1234_0000; pend[0] = 6; valid[0] = 1'b1;
    run(1);
    en[0] = 1'b1;
    run(4 * 128 + 20);
    en[0] = 1'b0;
    pend[0] = 0; valid[0] = 1'b0; inc_mode[0] = 0;
    run(4);

    // Underrun: enabled with nothing pending, then disabled.
    en[0] = 1'b1;
    run(150);
    en[0] = 1'b0;
    run(4);

    // Mid-frame disable around bit 10, then re-enable from the held sample.
    data[0] = $urandom; pend[0] = 2; valid[0] = 1'b1;
    run(2);
    en[0] = 1'b1;
    run(4 + 4 * 10);
    en[0] = 1'b0;
    run(10);
    en[0] = 1'b1;
    run(300);
    en[0] = 1'b0;
    run(4);

    // ClkDiv 1 instance.
    data[1] = $urandom; pend[1] = 3; valid[1] = 1'b1;
    run(1);
    en[1] = 1'b1;
    run(220);
    en[1] = 1'b0;
    run(4);

    // Randomized enables, gaps and data on both instances.
    gappy = 1;
    for (int seg = 0; seg < 10; seg++) begin
      for (int i = 0; i < 2; i++) begin
        en[i] = ($urandom_range(0, 3) != 0);
        pend[i] = pend[i] + $urandom_range(0, 3);
      end
      run($urandom_range(20, 400));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
